// File: rtl/serial_link_pkg.sv
// ---------------------------------------------------------------------------
// serial_link_pkg
// Shared definitions for the single-wire serial byte link (receive and
// transmit sides).
//   - state_t         : receiver state encoding (IDLE..STOP, 3 bits)
//   - STAT_* indices  : bit positions of the flags in the status byte
//   - DEFAULT_CLKS_PER_BIT : default bit period in clocks, shared with the
//                            transmitter so both ends agree
//   - even_parity_bit : parity bit that makes data plus parity even
// ---------------------------------------------------------------------------
package serial_link_pkg;

    // Receiver states; the numeric values are visible on the status byte.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Status byte layout: {valid, parity_err, frame_err, overrun, busy, state}
    localparam int STAT_VALID = 7;
    localparam int STAT_PERR  = 6;
    localparam int STAT_FERR  = 5;
    localparam int STAT_OVR   = 4;
    localparam int STAT_BUSY  = 3;

    localparam int DEFAULT_CLKS_PER_BIT = 4;

    // The bit a sender appends so that data plus parity has an even number
    // of ones.
    function automatic logic even_parity_bit(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_edge_2ff.sv
// ---------------------------------------------------------------------------
// sync_edge_2ff
// Two-flop synchroniser for an asynchronous input, followed by a third flop
// holding the previous synchronised value so that edges can be detected.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset, clears all three flops
//   i_d     : asynchronous input
//   o_sync  : synchronised value
//   o_prev  : synchronised value one clock earlier
//   o_rise  : o_sync is 1 and o_prev is 0
//   o_fall  : o_sync is 0 and o_prev is 1
// ---------------------------------------------------------------------------
module sync_edge_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_sync,
    output logic o_prev,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Shift the asynchronous input through the metastability flop, the
    // synchronised flop and the history flop. Resetting to 0 means a line
    // that is already low at reset release never looks like a falling edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_prev = r_prev;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/serial_byte_rx.sv
// ---------------------------------------------------------------------------
// serial_byte_rx
// Receive end of the single-wire serial byte link on TinyTapeout-style pins.
// Receives start(0), 8 data bits LSB first, even parity, stop(1); keeps the
// last byte and status flags until a rising edge on ack clears the flags.
// Ports:
//   io_in[0]   clk   : clock, rising edge
//   io_in[1]   rst_n : synchronous active-low reset
//   io_in[2]   rxd   : serial line, idle high, asynchronous
//   io_in[3]   view  : 0 shows the data byte, 1 shows the status byte
//   io_in[4]   ack   : rising edge clears valid and all error flags
//   io_in[7:5]       : ignored
//   io_out[7:0]      : data byte, or
//                      {valid, parity_err, frame_err, overrun, busy, state}
// Parameter:
//   CLKS_PER_BIT : clocks per serial bit, even and at least 2
// ---------------------------------------------------------------------------
module serial_byte_rx
    import serial_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic w_clk;
    logic w_rst_n;
    logic w_rxd;
    logic w_view;
    logic w_ack;

    assign w_clk   = io_in[0];
    assign w_rst_n = io_in[1];
    assign w_rxd   = io_in[2];
    assign w_view  = io_in[3];
    assign w_ack   = io_in[4];

    logic w_rxd_s;
    logic w_rxd_prev;
    logic w_rxd_rise;
    logic w_rxd_fall;
    logic w_ack_s;
    logic w_ack_prev;
    logic w_ack_rise;
    logic w_ack_fall;

    sync_edge_2ff u_rxd_sync (
        .i_clk   (w_clk),
        .i_rst_n (w_rst_n),
        .i_d     (w_rxd),
        .o_sync  (w_rxd_s),
        .o_prev  (w_rxd_prev),
        .o_rise  (w_rxd_rise),
        .o_fall  (w_rxd_fall)
    );

    sync_edge_2ff u_ack_sync (
        .i_clk   (w_clk),
        .i_rst_n (w_rst_n),
        .i_d     (w_ack),
        .o_sync  (w_ack_s),
        .o_prev  (w_ack_prev),
        .o_rise  (w_ack_rise),
        .o_fall  (w_ack_fall)
    );

    logic w_unused;
    assign w_unused = &{1'b0, io_in[7:5], w_rxd_prev, w_rxd_rise,
                        w_ack_s, w_ack_prev, w_ack_fall};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_par_bit;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_perr;
    logic             r_ferr;
    logic             r_ovr;
    logic             r_ack_pulse;

    // Receiver FSM and flag registers. START samples the line half a bit in
    // to reject glitches; every later bit is sampled one full bit period
    // after the previous sample, so sampling stays near mid-bit.
    // The ack edge is registered once, so the clear lands three edges after
    // the pin is first sampled high. Clearing is written first and frame
    // completion afterwards, so a completing frame overrides a simultaneous
    // ack; overrun is suppressed then because software has just consumed the
    // previous byte.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_ovr       <= 1'b0;
            r_ack_pulse <= 1'b0;
        end else begin
            r_ack_pulse <= w_ack_rise;

            if (r_ack_pulse) begin
                r_valid <= 1'b0;
                r_perr  <= 1'b0;
                r_ferr  <= 1'b0;
                r_ovr   <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_rxd_fall) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end

                ST_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (w_rxd_s) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_DATA;
                            r_idx   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rxd_s;
                        if (r_idx == 3'd7) begin
                            r_state <= ST_PARITY;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_PARITY: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt     <= '0;
                        r_par_bit <= w_rxd_s;
                        r_state   <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_STOP: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt   <= '0;
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                        r_perr  <= even_parity_bit(r_shift) ^ r_par_bit;
                        r_ferr  <= ~w_rxd_s;
                        r_ovr   <= r_valid & ~r_ack_pulse;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    logic [7:0] w_status;

    // Status byte assembled purely from registers so io_out has no path
    // from the serial line.
    always_comb begin
        w_status             = '0;
        w_status[STAT_VALID] = r_valid;
        w_status[STAT_PERR]  = r_perr;
        w_status[STAT_FERR]  = r_ferr;
        w_status[STAT_OVR]   = r_ovr;
        w_status[STAT_BUSY]  = (r_state != ST_IDLE);
        w_status[2:0]        = r_state;
    end

    assign io_out = w_view ? w_status : r_data;

endmodule

// File: tb/tb_serial_byte_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_byte_rx
// Self-checking bench for serial_byte_rx with CLKS_PER_BIT = 4. Directed
// frames from a table, hand sequences for ack latency, frame error, glitch
// and mid-frame reset, then random frames checked against a flag model.
// ---------------------------------------------------------------------------
module tb_serial_byte_rx;

    localparam int CPB = 4;
    localparam int FRAME_EDGES = 11 * CPB;

    logic       clk;
    logic       rstN;
    logic       rxd;
    logic       view;
    logic       ack;
    logic [2:0] junk;
    logic [7:0] ioIn;
    logic [7:0] ioOut;

    int nVec;
    int nMis;

    assign ioIn = {junk, ack, view, rxd, rstN, clk};

    serial_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
        .io_in  (ioIn),
        .io_out (ioOut)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against any unexpected hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         ackEdge;
        logic       ackBefore;
        logic [7:0] expPre;
        logic [7:0] expData;
        logic [7:0] expStatus;
    } frameVec_t;

    frameVec_t vecs[5];

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readOut(input logic v, output logic [7:0] val);
        view = v;
        #1;
        val = ioOut;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Send one frame starting at the next edge (edge 0). ack is held high
    // for edges ackEdge and ackEdge+1 when ackEdge >= 0. preStatus is the
    // status byte after edge 43; the task returns just after edge 44.
    task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop,
                                 input int ackEdge, input logic tailLevel,
                                 output logic [7:0] preStatus);
        logic [10:0] bits;
        bits = {stop, par, data, 1'b0};
        preStatus = 8'h00;
        for (int e = 0; e < FRAME_EDGES; e++) begin
            rxd = bits[e / CPB];
            ack = (ackEdge >= 0) && (e >= ackEdge) && (e < ackEdge + 2);
            tick();
            if (e == FRAME_EDGES - 1) readOut(1'b1, preStatus);
        end
        ack = 1'b0;
        rxd = tailLevel;
        tick();
    endtask

    task automatic ackPulse();
        ack = 1'b1;
        tick();
        tick();
        ack = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        logic [7:0] v0;
        logic [7:0] v1;
        logic [7:0] pre;
        logic       modelValid;
        logic [7:0] rData;
        logic       rPar;
        logic       rStop;
        logic       rAckBefore;
        int         rAckEdge;
        logic [7:0] expStat;

        nVec = 0;
        nMis = 0;
        junk = 3'b101;
        rxd  = 1'b1;
        view = 1'b0;
        ack  = 1'b0;
        rstN = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, -1, 1'b0, 8'h0C, 8'hA5, 8'h80};
        vecs[1] = '{8'h01, 1'b0, 1'b1, -1, 1'b1, 8'h0C, 8'h01, 8'hC0};
        vecs[2] = '{8'h11, 1'b0, 1'b1, -1, 1'b1, 8'h0C, 8'h11, 8'h80};
        vecs[3] = '{8'h22, 1'b0, 1'b1, -1, 1'b0, 8'h8C, 8'h22, 8'h90};
        vecs[4] = '{8'h33, 1'b0, 1'b1, 41, 1'b0, 8'h9C, 8'h33, 8'h80};

        // Reset held for two edges; both views must read zero.
        tick();
        tick();
        readOut(1'b0, v0);
        readOut(1'b1, v1);
        checkOutput("resetView0", v0, 8'h00);
        checkOutput("resetView1", v1, 8'h00);
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Directed frames from the table.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].ackBefore) ackPulse();
            junk = 3'($urandom);
            applyStimulus(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].ackEdge, 1'b1, pre);
            readOut(1'b0, v0);
            readOut(1'b1, v1);
            checkOutput($sformatf("vec%0dEdge43", i), pre, vecs[i].expPre);
            checkOutput($sformatf("vec%0dData", i), v0, vecs[i].expData);
            checkOutput($sformatf("vec%0dStatus", i), v1, vecs[i].expStatus);
            tick();
            tick();
        end

        // Ack latency: pin high at edge 0, flags still set after edge 2,
        // cleared after edge 3, data kept.
        ack = 1'b1;
        tick();
        tick();
        ack = 1'b0;
        tick();
        readOut(1'b1, v1);
        checkOutput("ackEdge2", v1, 8'h80);
        tick();
        readOut(1'b1, v1);
        readOut(1'b0, v0);
        checkOutput("ackEdge3Status", v1, 8'h00);
        checkOutput("ackEdge3Data", v0, 8'h33);
        tick();

        // Frame error, line then held low: no new start while low.
        applyStimulus(8'h5A, 1'b0, 1'b0, -1, 1'b0, pre);
        readOut(1'b0, v0);
        readOut(1'b1, v1);
        checkOutput("ferrData", v0, 8'h5A);
        checkOutput("ferrStatus", v1, 8'hA0);
        for (int i = 0; i < 20; i++) begin
            tick();
            readOut(1'b1, v1);
            checkOutput($sformatf("ferrLow%0d", i), v1, 8'hA0);
        end
        rxd = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        readOut(1'b1, v1);
        checkOutput("ferrLineHigh", v1, 8'hA0);
        applyStimulus(8'h3C, 1'b0, 1'b1, -1, 1'b1, pre);
        readOut(1'b0, v0);
        readOut(1'b1, v1);
        checkOutput("afterFerrData", v0, 8'h3C);
        checkOutput("afterFerrStatus", v1, 8'h90);
        ackPulse();

        // One-cycle glitch: START at edge 2, aborted at edge 4.
        rxd = 1'b0;
        tick();
        rxd = 1'b1;
        tick();
        tick();
        readOut(1'b1, v1);
        checkOutput("glitchStart", v1, 8'h09);
        tick();
        tick();
        readOut(1'b1, v1);
        checkOutput("glitchAbort", v1, 8'h00);
        for (int i = 0; i < 3; i++) tick();

        // Reset during DATA, then a clean frame.
        rxd = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        readOut(1'b1, v1);
        checkOutput("midFrameData", v1, 8'h0A);
        rstN = 1'b0;
        tick();
        readOut(1'b0, v0);
        readOut(1'b1, v1);
        checkOutput("midResetView0", v0, 8'h00);
        checkOutput("midResetView1", v1, 8'h00);
        rstN = 1'b1;
        rxd  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        applyStimulus(8'hC3, 1'b0, 1'b1, -1, 1'b1, pre);
        readOut(1'b0, v0);
        readOut(1'b1, v1);
        checkOutput("postResetData", v0, 8'hC3);
        checkOutput("postResetStatus", v1, 8'h80);

        // Random frames against a flag model: valid is set by every frame,
        // overrun only if an unacknowledged byte was still pending.
        modelValid = 1'b1;
        for (int n = 0; n < 30; n++) begin
            rData      = 8'($urandom);
            rPar       = 1'(($countones(rData) % 2) != 0) ^ 1'($urandom_range(0, 3) == 0);
            rStop      = 1'($urandom_range(0, 4) != 0);
            rAckBefore = 1'($urandom_range(0, 3) == 0);
            rAckEdge   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 41)) : -1;
            junk       = 3'($urandom);
            if (rAckBefore) begin
                ackPulse();
                modelValid = 1'b0;
            end
            applyStimulus(rData, rPar, rStop, rAckEdge, 1'b1, pre);
            expStat = 8'h00;
            expStat[7] = 1'b1;
            expStat[6] = 1'((($countones(rData) + int'(rPar)) % 2) != 0);
            expStat[5] = ~rStop;
            expStat[4] = modelValid && (rAckEdge < 0);
            modelValid = 1'b1;
            readOut(1'b0, v0);
            readOut(1'b1, v1);
            checkOutput($sformatf("rand%0dData", n), v0, rData);
            checkOutput($sformatf("rand%0dStatus", n), v1, expStat);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
